// File: rtl/sampler_pkg.sv
// Shared types and constants for the polynomial sampler datapath.
// Holds the modulus, polynomial length, mode/state enums and the binomial lane mapping.
package sampler_pkg;

    localparam int Q       = 3329;
    localparam int N_COEFF = 256;

    typedef enum logic {
        MODE_BIN = 1'b0,
        MODE_REJ = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Sign-magnitude lane {sign, m[1:0]} -> value in [0, q-1]; negative zero maps to 0.
    function automatic logic [11:0] cbd_to_coeff(input logic [2:0] lane, input int q);
        logic [11:0] mag;
        mag = {10'd0, lane[1:0]};
        if (lane[2] && (mag != 12'd0)) begin
            return 12'(q) - mag;
        end
        return mag;
    endfunction

endpackage

// File: rtl/coeff_fifo.sv
// Synchronous coefficient FIFO: up to two pushes and one pop per cycle.
// Show-ahead read port; i_push_d0 is always the older of the two pushed words.
module coeff_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clr,
    input  logic [1:0]                   i_push_n,
    input  logic [WIDTH-1:0]             i_push_d0,
    input  logic [WIDTH-1:0]             i_push_d1,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_pop_d,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_occ
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_occ;
    logic [PW-1:0]    w_wr_ptr1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_wr_ptr1 = ptr_inc(r_wr_ptr);

    always_ff @(posedge clk) begin
        if (i_push_n != 2'd0) r_mem[r_wr_ptr]  <= i_push_d0;
        if (i_push_n == 2'd2) r_mem[w_wr_ptr1] <= i_push_d1;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            case (i_push_n)
                2'd1:    r_wr_ptr <= w_wr_ptr1;
                2'd2:    r_wr_ptr <= ptr_inc(w_wr_ptr1);
                default: r_wr_ptr <= r_wr_ptr;
            endcase
            if (i_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_occ <= r_occ + CW'(i_push_n) - CW'(i_pop);
        end
    end

    assign o_pop_d = r_mem[r_rd_ptr];
    assign o_empty = (r_occ == '0);
    assign o_occ   = r_occ;

endmodule

// File: rtl/poly_collector.sv
// Collects one polynomial of N_COEFF coefficients from a two-lane sampler stream
// and writes them in order to coefficient memory.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; outputs quiet, coeff_cnt holds last value
// S_COLLECT | accepting sample words, draining the FIFO into memory writes
// S_DONE    | single cycle with done asserted, returns to S_IDLE
module poly_collector #(
    parameter int N_COEFF    = sampler_pkg::N_COEFF,
    parameter int Q          = sampler_pkg::Q,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic [1:0]  in_ok,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [8:0]  coeff_cnt
);

    import sampler_pkg::*;

    localparam int          OCW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [8:0]  N_CAP = 9'(N_COEFF);

    state_t      r_state;
    mode_t       r_mode;
    logic [8:0]  r_push_cnt;
    logic [8:0]  r_coeff_cnt;
    logic        r_wr_en;
    logic [7:0]  r_wr_addr;
    logic [11:0] r_wr_data;
    logic        r_done;

    logic [11:0]    w_val0;
    logic [11:0]    w_val1;
    logic           w_ok0;
    logic           w_ok1;
    logic           w_in_ready;
    logic           w_hs;
    logic           w_take0;
    logic           w_take1;
    logic [1:0]     w_push_n;
    logic [11:0]    w_push_d0;
    logic           w_pop;
    logic           w_clr;
    logic           w_empty;
    logic [11:0]    w_fifo_dout;
    logic [OCW-1:0] w_occ;

    always_comb begin
        w_val0 = in_data[11:0];
        w_val1 = in_data[23:12];
        w_ok0  = in_ok[0] && (in_data[11:0]  < 12'(Q));
        w_ok1  = in_ok[1] && (in_data[23:12] < 12'(Q));
        if (r_mode == MODE_BIN) begin
            w_val0 = cbd_to_coeff(in_data[2:0], Q);
            w_val1 = cbd_to_coeff(in_data[5:3], Q);
            w_ok0  = 1'b1;
            w_ok1  = 1'b1;
        end
    end

    // Two free slots guarantee a full two-lane push never overflows, even without a pop.
    assign w_in_ready = (r_state == S_COLLECT) && (int'(w_occ) <= FIFO_DEPTH - 2)
                        && (r_push_cnt < N_CAP);
    assign w_hs      = in_valid && w_in_ready;
    assign w_take0   = w_hs && w_ok0 && (r_push_cnt < N_CAP);
    assign w_take1   = w_hs && w_ok1 && ((r_push_cnt + 9'(w_take0)) < N_CAP);
    assign w_push_n  = {1'b0, w_take0} + {1'b0, w_take1};
    assign w_push_d0 = w_take0 ? w_val0 : w_val1;
    assign w_pop     = (r_state == S_COLLECT) && !w_empty && (r_coeff_cnt < N_CAP);
    assign w_clr     = (r_state == S_IDLE) && start;

    coeff_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (12)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_push_n  (w_push_n),
        .i_push_d0 (w_push_d0),
        .i_push_d1 (w_val1),
        .i_pop     (w_pop),
        .o_pop_d   (w_fifo_dout),
        .o_empty   (w_empty),
        .o_occ     (w_occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= MODE_BIN;
            r_push_cnt  <= '0;
            r_coeff_cnt <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_COLLECT;
                        r_mode      <= mode_t'(mode);
                        r_push_cnt  <= '0;
                        r_coeff_cnt <= '0;
                    end
                end
                S_COLLECT: begin
                    r_push_cnt <= r_push_cnt + 9'(w_push_n);
                    if (w_pop) begin
                        r_wr_en     <= 1'b1;
                        r_wr_addr   <= r_coeff_cnt[7:0];
                        r_wr_data   <= w_fifo_dout;
                        r_coeff_cnt <= r_coeff_cnt + 9'd1;
                    end else if (r_coeff_cnt == N_CAP) begin
                        // last write has already left; finish one cycle later so wr_en is low in S_DONE
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign coeff_cnt = r_coeff_cnt;

endmodule
